freq_meter: RTL and testbench

// - Receive side of the clock-divider output: samples a slow divided clock (CP) in the CLK domain.
// - Generates single-cycle RISE/FALL enables, measures period and high time in CLK cycles,
//   and flags lock/timeout.
// - Used by CPU debug/step logic to qualify the divided clock and confirm divider settings.

---
 rtl/freq_meter_pkg.sv | 15 +
 rtl/freq_meter_if.sv | 46 ++++
 rtl/freq_meter_sync_edge_det.sv | 48 ++++
 rtl/freq_meter.sv | 132 +++++++++++++
 tb/tb_freq_meter.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the divided-clock frequency meter.
// Contents:
//   state_t    - measurement FSM encoding (IDLE / ARMED / MEASURE)
//   DEF_CNT_W  - default width of the period / high-time counters
package freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    localparam int DEF_CNT_W = 32;

endpackage

// File: rtl/freq_meter_if.sv
// Signal bundle between the frequency meter and its user.
// master modport: the user side (drives cp_in/en, observes results).
// slave modport : the meter itself.
// Signals:
//   cp_in        divided clock under measurement (asynchronous to clk)
//   en           measurement enable, 0 = synchronous clear to IDLE
//   rise/fall    1-cycle pulses per synchronised CP edge
//   period       clk cycles between the last two rises
//   high_time    clk cycles from the last rise to the following fall
//   period_valid 1-cycle pulse when period is updated
//   locked       two consecutive equal periods measured
//   timeout_flag sticky, no rise for TIMEOUT cycles
//   cp_sync      synchronised copy of cp_in (debug)
//   state        current FSM state (debug)
// Pulse semantics: rise, fall and period_valid are single-cycle strobes
// with no back-pressure; period/locked/period_valid change on the same edge
// and period is stable whenever period_valid is high.
interface freq_meter_if
    import freq_meter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             cp_in;
    logic             en;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             locked;
    logic             timeout_flag;
    logic             cp_sync;
    state_t           state;

    modport master (
        output cp_in, en,
        input  rise, fall, period, high_time, period_valid, locked,
               timeout_flag, cp_sync, state
    );

    modport slave (
        input  cp_in, en,
        output rise, fall, period, high_time, period_valid, locked,
               timeout_flag, cp_sync, state
    );
endinterface

// File: rtl/freq_meter_sync_edge_det.sv
// Synchroniser chain plus registered edge detector for an asynchronous
// slow clock.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   d           asynchronous input
//   q           synchronised level (last stage of the chain)
//   rise, fall  registered 1-cycle pulses; latency SYNC_STAGES+1 edges
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    // Edges are suppressed until the chain and its delayed copy both hold
    // real samples, so a high input at reset release never looks like a rise.
    localparam int FILL_MAX = SYNC_STAGES + 1;
    localparam int FILL_W   = $clog2(FILL_MAX + 1);

    logic [SYNC_STAGES-1:0] chain;
    logic                   q_d;
    logic [FILL_W-1:0]      fill;
    logic                   primed;

    assign q      = chain[SYNC_STAGES-1];
    assign primed = (fill == FILL_W'(FILL_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
            q_d   <= 1'b0;
            fill  <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
            q_d   <= q;
            if (!primed) begin
                fill <= fill + FILL_W'(1);
            end
            rise <= primed & q & ~q_d;
            fall <= primed & ~q & q_d;
        end
    end
endmodule

// File: rtl/freq_meter.sv
// Frequency meter for a slow divided clock sampled in the clk domain.
// Measures period and high time in clk cycles, flags lock (two equal
// consecutive periods) and timeout (no rise for TIMEOUT cycles).
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   bus         freq_meter_if slave modport (see interface header)
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT     = 1000000,
    parameter int SYNC_STAGES = 2
) (
    input logic         clk,
    input logic         rst_n,
    freq_meter_if.slave bus
);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t           state_q;
    state_t           state_d;
    logic             rise;
    logic             fall;
    logic             cp_sync;
    logic             timeout_hit;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] prev_period;
    logic             prev_valid;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] high_time_q;
    logic             period_valid_q;
    logic             locked_q;
    logic             timeout_flag_q;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.cp_in),
        .q     (cp_sync),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A rise in the same cycle as the counter reaching TIMEOUT wins.
    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        if (!bus.en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_ARMED;
                ST_ARMED: if (rise) state_d = ST_MEASURE;
                ST_MEASURE: begin
                    if (!rise && cnt == TIMEOUT_C) begin
                        timeout_hit = 1'b1;
                        state_d     = ST_ARMED;
                    end
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            prev_period    <= '0;
            prev_valid     <= 1'b0;
            period_q       <= '0;
            high_time_q    <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_flag_q <= 1'b0;
        end else begin
            period_valid_q <= 1'b0;
            if (!bus.en) begin
                // period/high_time deliberately hold their last values
                cnt            <= '0;
                prev_valid     <= 1'b0;
                locked_q       <= 1'b0;
                timeout_flag_q <= 1'b0;
            end else if (state_q == ST_ARMED) begin
                // first rise only starts the count; no period is published
                if (rise) begin
                    cnt            <= CNT_W'(1);
                    timeout_flag_q <= 1'b0;
                end
            end else if (state_q == ST_MEASURE) begin
                if (rise) begin
                    period_q       <= cnt;
                    period_valid_q <= 1'b1;
                    prev_period    <= cnt;
                    prev_valid     <= 1'b1;
                    locked_q       <= prev_valid && (cnt == prev_period);
                    cnt            <= CNT_W'(1);
                    timeout_flag_q <= 1'b0;
                end else if (timeout_hit) begin
                    timeout_flag_q <= 1'b1;
                    locked_q       <= 1'b0;
                    prev_valid     <= 1'b0;
                    cnt            <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (fall) begin
                    high_time_q <= cnt;
                end
            end
        end
    end

    assign bus.rise         = rise;
    assign bus.fall         = fall;
    assign bus.cp_sync      = cp_sync;
    assign bus.period       = period_q;
    assign bus.high_time    = high_time_q;
    assign bus.period_valid = period_valid_q;
    assign bus.locked       = locked_q;
    assign bus.timeout_flag = timeout_flag_q;
    assign bus.state        = state_q;
endmodule

// File: tb/tb_freq_meter.sv
// Directed testbench for freq_meter (CNT_W=16, TIMEOUT=50, SYNC_STAGES=2).
module tb_freq_meter;
    import freq_meter_pkg::*;

    localparam int CNT_W = 16;

    logic clk;
    logic rst_n;

    freq_meter_if #(.CNT_W(CNT_W)) bus ();

    freq_meter #(
        .CNT_W       (CNT_W),
        .TIMEOUT     (50),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_cmp;
    int n_err;
    int cyc;
    int rise_cnt;
    int last_rise_cyc;
    int pv_cnt;
    int last_pv_cyc;
    int first_lock_pv;
    int gap_bad;
    bit gap_chk;
    bit both_seen;
    logic [CNT_W-1:0] pv_period;
    logic             pv_locked;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one clock; sample outputs 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (bus.rise) begin
            rise_cnt++;
            last_rise_cyc = cyc;
        end
        if (bus.rise && bus.fall) both_seen = 1'b1;
        if (bus.period_valid) begin
            if (gap_chk && last_pv_cyc > 0 && (cyc - last_pv_cyc) != 4) gap_bad++;
            last_pv_cyc = cyc;
            pv_cnt++;
            pv_period = bus.period;
            pv_locked = bus.locked;
            if (bus.locked && first_lock_pv == 0) first_lock_pv = pv_cnt;
        end
    endtask

    // drive n cycles of a square wave (period per, high for hi cycles);
    // en is held low for the first en_off cycles
    task automatic wave(input int per, input int hi, input int n, input int en_off);
        for (int i = 0; i < n; i++) begin
            bus.cp_in = ((i % per) < hi);
            bus.en    = (i < en_off) ? 1'b0 : 1'b1;
            tick();
        end
    endtask

    // ---------------- directed sequence ----------------
    int rise_at;
    int snap;
    int to_lat;
    int start_cyc;

    initial begin
        n_cmp = 0; n_err = 0; cyc = 0; rise_cnt = 0; last_rise_cyc = 0;
        pv_cnt = 0; last_pv_cyc = 0; first_lock_pv = 0; gap_bad = 0;
        gap_chk = 1'b0; both_seen = 1'b0; pv_period = '0; pv_locked = 1'b0;

        rst_n = 1'b0;
        bus.cp_in = 1'b0;
        bus.en = 1'b0;
        repeat (3) tick();
        chk("rst_period", bus.period, 0);
        chk("rst_high_time", bus.high_time, 0);
        chk("rst_pv", bus.period_valid, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_timeout", bus.timeout_flag, 0);
        chk("rst_state", bus.state, ST_IDLE);
        rst_n = 1'b1;
        repeat (4) tick();
        chk("en0_state", bus.state, ST_IDLE);

        // 1: period 4, 50% duty
        bus.en = 1'b1;
        tick();
        chk("armed_state", bus.state, ST_ARMED);
        pv_cnt = 0; first_lock_pv = 0; last_pv_cyc = 0; rise_cnt = 0;
        gap_chk = 1'b1;
        wave(4, 2, 40, 0);
        gap_chk = 1'b0;
        chk("t1_rises", rise_cnt, 10);
        chk("t1_pv_count", pv_cnt, 9);
        chk("t1_pv_gap", gap_bad, 0);
        chk("t1_period", bus.period, 4);
        chk("t1_high_time", bus.high_time, 2);
        chk("t1_lock_pv_idx", first_lock_pv, 2);
        chk("t1_locked", bus.locked, 1);

        // 2: edge-to-RISE latency
        bus.cp_in = 1'b1;
        rise_at = 0;
        snap = rise_cnt;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (bus.rise && rise_at == 0) rise_at = k;
        end
        chk("t2_rise_latency", rise_at, 3);
        chk("t2_rise_single", rise_cnt - snap, 1);

        // 3: timeout after lock, then resume with period 8
        wave(4, 2, 20, 0);
        chk("t3_locked_before", bus.locked, 1);
        bus.cp_in = 1'b0;
        to_lat = -1;
        start_cyc = cyc;
        while (bus.timeout_flag !== 1'b1 && (cyc - start_cyc) < 100) tick();
        if (bus.timeout_flag === 1'b1) to_lat = cyc - last_rise_cyc;
        chk("t3_timeout_latency", to_lat, 51);
        chk("t3_timeout_flag", bus.timeout_flag, 1);
        chk("t3_locked_after", bus.locked, 0);
        chk("t3_state_armed", bus.state, ST_ARMED);
        snap = pv_cnt;
        wave(8, 4, 8, 0);
        chk("t3_flag_cleared", bus.timeout_flag, 0);
        chk("t3_no_pv_on_rearm", pv_cnt - snap, 0);
        wave(8, 4, 8, 0);
        chk("t3_pv_count", pv_cnt - snap, 1);
        chk("t3_period8", pv_period, 8);
        chk("t3_high4", bus.high_time, 4);

        // 4: switch period 4 -> 6 while locked
        wave(4, 2, 24, 0);
        chk("t4_period4", bus.period, 4);
        chk("t4_locked4", bus.locked, 1);
        wave(6, 3, 6, 0);
        wave(6, 3, 6, 0);
        chk("t4_first6_period", pv_period, 6);
        chk("t4_first6_unlocked", pv_locked, 0);
        wave(6, 3, 6, 0);
        chk("t4_second6_period", pv_period, 6);
        chk("t4_second6_locked", pv_locked, 1);
        chk("t4_high3", bus.high_time, 3);

        // 5: EN dropped for 3 cycles with PERIOD=4
        wave(4, 2, 20, 0);
        chk("t5_locked_before", bus.locked, 1);
        snap = pv_cnt;
        wave(4, 2, 4, 3);
        chk("t5_locked_cleared", bus.locked, 0);
        chk("t5_period_held", bus.period, 4);
        chk("t5_no_pv", pv_cnt - snap, 0);
        chk("t5_state_armed", bus.state, ST_ARMED);
        wave(4, 2, 8, 0);
        chk("t5_pv_after_2", pv_cnt - snap, 1);
        chk("t5_unlocked_2", bus.locked, 0);
        wave(4, 2, 4, 0);
        chk("t5_pv_after_3", pv_cnt - snap, 2);
        chk("t5_relocked", bus.locked, 1);

        // 6: asynchronous reset mid-period with CP high
        wave(4, 2, 6, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_period", bus.period, 0);
        chk("t6_async_high", bus.high_time, 0);
        chk("t6_async_locked", bus.locked, 0);
        chk("t6_async_state", bus.state, ST_IDLE);
        #2;
        rst_n = 1'b1;
        snap = rise_cnt;
        repeat (8) tick();
        chk("t6_no_spurious_rise", rise_cnt - snap, 0);
        chk("t6_state_armed", bus.state, ST_ARMED);
        chk("t6_period_zero", bus.period, 0);

        chk("rise_fall_exclusive", both_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
